// File: rtl/sanity_count_checker.sv
// Checks that a received stream of count words increments by one per accepted beat.
// It locks after a run of correct successors, then flags and counts any break in the sequence.
module sanity_count_checker #(
    parameter int DATA_WIDTH     = 4,
    parameter int ERR_WIDTH      = 8,
    parameter int LOCK_THRESHOLD = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  locked,
    output logic                  error,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ERR_WIDTH-1:0]  beat_count,
    output logic [1:0]            dbg_state_o
);

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // in_ready simply mirrors enable, so there is no internal backpressure.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKING = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam logic [3:0]           LOCK_TH = 4'(LOCK_THRESHOLD);
    localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] ref_q, ref_d;
    logic [3:0]            streak_q, streak_d;
    logic                  locked_q;
    logic                  error_q, error_d;
    logic [ERR_WIDTH-1:0]  err_count_q, err_count_d;
    logic [ERR_WIDTH-1:0]  beat_count_q, beat_count_d;

    logic                  beat;
    logic [DATA_WIDTH-1:0] expected;
    logic                  match;

    assign in_ready = enable;
    assign beat     = in_valid && enable;
    // Modular increment: the all-ones value followed by zero counts as correct.
    assign expected = ref_q + DATA_WIDTH'(1);
    assign match    = (in_data == expected);

    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        streak_d = streak_q;
        error_d  = 1'b0;
        if (state_q == IDLE) begin
            if (enable) state_d = ACQUIRE;
        end else if (!enable) begin
            state_d = IDLE;
        end else if (beat) begin
            ref_d = in_data;
            case (state_q)
                ACQUIRE: begin
                    streak_d = 4'd0;
                    state_d  = LOCKING;
                end
                LOCKING: begin
                    if (match) begin
                        streak_d = streak_q + 4'd1;
                        if (streak_q + 4'd1 == LOCK_TH) state_d = LOCKED;
                    end else begin
                        streak_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        error_d  = 1'b1;
                        streak_d = 4'd0;
                        state_d  = LOCKING;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Clear takes precedence over any increment in the same cycle.
    always_comb begin
        err_count_d  = err_count_q;
        beat_count_d = beat_count_q;
        if (clear) begin
            err_count_d  = '0;
            beat_count_d = '0;
        end else begin
            if (error_d && err_count_q != ERR_MAX) err_count_d = err_count_q + ERR_WIDTH'(1);
            if (beat) beat_count_d = beat_count_q + ERR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ref_q        <= '0;
            streak_q     <= 4'd0;
            locked_q     <= 1'b0;
            error_q      <= 1'b0;
            err_count_q  <= '0;
            beat_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ref_q        <= ref_d;
            streak_q     <= streak_d;
            locked_q     <= (state_d == LOCKED);
            error_q      <= error_d;
            err_count_q  <= err_count_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign locked      = locked_q;
    assign error       = error_q;
    assign err_count   = err_count_q;
    assign beat_count  = beat_count_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/sanity_count_checker.md
SANITY_COUNT_CHECKER -- requirements
Module: sanity_count_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4: width of the checked count word.
REQ-002 SHALL have parameter ERR_WIDTH, default 8: width of the error and beat counters.
REQ-003 SHALL have parameter LOCK_THRESHOLD, default 4, legal range 1..15: consecutive correct successors needed to lock.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising edge active.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1 bit: checker active.
REQ-007 SHALL have port clear, input, 1 bit: synchronous clear of err_count and beat_count.
REQ-008 SHALL have port in_data, input, DATA_WIDTH bits: received count word.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: checker accepts a beat.
REQ-011 SHALL have port locked, output, 1 bit: the checker is in the LOCKED state.
REQ-012 SHALL have port error, output, 1 bit: one-cycle pulse on a mismatch while locked.
REQ-013 SHALL have port err_count, output, ERR_WIDTH bits: saturating count of mismatches.
REQ-014 SHALL have port beat_count, output, ERR_WIDTH bits: wrapping count of accepted beats.

Function
REQ-015 SHALL drive in_ready = enable, combinationally; a beat is accepted when in_valid && in_ready on a rising edge.
REQ-016 SHALL implement the FSM states IDLE, ACQUIRE, LOCKING and LOCKED, with registers ref (DATA_WIDTH) and streak (4 bits).
REQ-017 SHALL, in IDLE, go to ACQUIRE on the next edge when enable=1, otherwise stay in IDLE.
REQ-018 SHALL, in ACQUIRE, on an accepted beat: set ref to in_data, set streak to 0, and go to LOCKING.
REQ-019 SHALL define the expected value as (ref + 1) mod 2^DATA_WIDTH, so that the maximum value followed by 0 is correct.
REQ-020 SHALL, in LOCKING, on an accepted beat equal to expected: set ref to in_data and increment streak; when streak+1 == LOCK_THRESHOLD, go to LOCKED.
REQ-021 SHALL, in LOCKING, on an accepted beat not equal to expected: set ref to in_data, set streak to 0, stay in LOCKING, and leave error and err_count unaffected.
REQ-022 SHALL, in LOCKED, on an accepted beat equal to expected: set ref to in_data and stay in LOCKED.
REQ-023 SHALL, in LOCKED, on an accepted beat not equal to expected: set error=1 for exactly the next cycle, increment err_count (saturating at all-ones), set ref to in_data, set streak to 0, and go to LOCKING.
REQ-024 SHALL hold state, ref and streak unchanged in any cycle with no accepted beat.
REQ-025 SHALL make locked a registered output equal to (state == LOCKED).
REQ-026 SHALL make error a registered output with latency one cycle from the offending accepted beat.
REQ-027 SHALL increment beat_count, wrapping, on every accepted beat in any state.
REQ-028 SHALL, when enable=0 in a non-IDLE state, go to IDLE on the next edge and leave err_count and beat_count unchanged.
REQ-029 SHALL, on clear=1, zero err_count and beat_count on the next edge; clear SHALL win over a simultaneous increment; clear SHALL NOT affect state, ref or streak.
REQ-030 SHALL, on a mismatch in LOCKED concurrent with clear=1, still pulse error, but err_count SHALL read 0 afterwards.

Reset
REQ-031 SHALL, on reset=1 at a rising edge, set state=IDLE, ref=0, streak=0, locked=0, error=0, err_count=0 and beat_count=0.
REQ-032 SHALL give reset priority over enable, clear and in_valid; a reset asserted mid-stream discards lock, and a new lock then needs a fresh ACQUIRE plus LOCK_THRESHOLD correct beats.
REQ-033 SHALL keep in_ready = enable during reset, but no beat SHALL be counted in a reset cycle.

Verification
REQ-034 SHALL cover lock-up: defaults, enable=1, in_valid=1 with data 0,1,2,3,4 on consecutive cycles -> locked=1 in the cycle after beat 4, err_count=0, beat_count=5.
REQ-035 SHALL cover wrap-around: while locked, beats 14,15,0,1 -> no error, locked stays 1.
REQ-036 SHALL cover a mismatch while locked: beats 5,6,9 -> error=1 for exactly one cycle after beat 9, err_count=1, locked=0; then 10,11,12,13 -> locked=1 again.
REQ-037 SHALL cover backpressure and gaps: in_valid toggled 1,0,1,0 with data 0,x,1,x, then enable=0 for 3 cycles -> beat_count=2, state=IDLE, and in_ready=0 while enable=0.
REQ-038 SHALL cover saturation and clear: with ERR_WIDTH=2, force 5 locked mismatches -> err_count=3; assert clear together with a 6th mismatch -> error pulses and err_count=0.
REQ-039 SHALL cover reset mid-operation: assert reset for 1 cycle while locked with err_count=2 -> all outputs 0, and the next beats 7,8,9,10,11 relock without any error pulse.
